freq_meas_scheduler: RTL
========================

// Module: freq_meas_scheduler
// PURPOSE
//  Time-multiplexes one shared gated edge-counting engine across the four pulse_in channels.
//  Round-robin over the enabled channels: select, settle, gate for a fixed window, scale, store.
//  Produces the per-channel 32-bit frequency registers (Hz) consumed downstream.
//  Sits between the raw pulse pins and the register/readout logic of the frequency-measurement subsystem.
// PARAMETERS
//  CLK_HZ         20_000_000  system clock frequency, Hz
//  GATE_CYCLES    20_000_000  gate window length in clk cycles (1 s default); must divide CLK_HZ
//  SETTLE_CYCLES  4           post-switch cycles with edges discarded (>=2, covers synchroniser)
//  FREQ_MULT      CLK_HZ/GATE_CYCLES  derived localparam, count->Hz scale
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous reset, active-high
//  pulse_in_0  in   1   async pulse input ch0 (1 Hz..200 kHz)
//  pulse_in_1  in   1   async pulse input ch1
//  pulse_in_2  in   1   async pulse input ch2
//  pulse_in_3  in   1   async pulse input ch3
//  ch_en       in   4   per-channel enable mask, bit n = channel n
//  freq_out_0  out  32  last measured frequency ch0, Hz
//  freq_out_1  out  32  ch1
//  freq_out_2  out  32  ch2
//  freq_out_3  out  32  ch3
//  freq_valid  out  4   bit n set once freq_out_n holds a completed measurement
//  upd_stb     out  1   one-cycle pulse when a result is written
//  upd_ch      out  2   channel written on upd_stb; holds value otherwise
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: freq_out_* = 0, freq_valid = 0, upd_stb = 0, upd_ch = 0, busy = 0, FSM = IDLE, last_ch = 3.
//  All four inputs pass through 2-FF synchronisers continuously (not only the selected one).
//  FSM states:
//   IDLE   : ch_en==0 -> stay; else -> SELECT next cycle.
//   SELECT : 1 cycle; cur_ch = first enabled ch after last_ch (wraps 3->0);
//            edge detector prev-reg loaded from synced cur_ch (no spurious edge) -> SETTLE.
//            If ch_en==0 here -> IDLE.
//   SETTLE : exactly SETTLE_CYCLES cycles; edges ignored; count cleared -> GATE.
//   GATE   : exactly GATE_CYCLES cycles; count += 1 per synced rising edge of cur_ch;
//            edge in last gate cycle counted; count saturates at all-ones -> STORE.
//   STORE  : 1 cycle; if ch_en[cur_ch] still set: freq_out[cur_ch] = min(count*FREQ_MULT, 2^32-1)
//            (64-bit product, then saturate), freq_valid[cur_ch]=1, upd_stb=1, upd_ch=cur_ch;
//            else result discarded, no strobe. last_ch = cur_ch -> SELECT.
//  Latency: result of a gate visible on freq_out the cycle after STORE (registered).
//  Cycle per channel = 1 + SETTLE_CYCLES + GATE_CYCLES + 1.
//  ch_en bit cleared: freq_valid[n] cleared next cycle, freq_out_n held; in-progress gate on n runs to
//   completion then is discarded (no strobe). Bit set mid-sweep: joins at next SELECT.
//  Single enabled channel: re-measured back-to-back (SELECT re-picks it).
//  Edges between gates are not counted (dead time of SELECT+SETTLE+STORE).
//  rst asserted mid-operation: everything returns to reset values next cycle, no partial write.
// STRUCTURE
//  Package freq_meas_pkg: NUM_CH=4, CH_W=2, CNT_W=32, state enum {IDLE,SELECT,SETTLE,GATE,STORE}.
//  Sub-module pulse_sync_edge (2-FF sync + synced-level output), instantiated 4x;
//   edge detect on the muxed synced level lives in the scheduler.
//  Scheduler holds FSM, round-robin pointer, gate/settle timer, shared counter, scale/saturate, result regs.
// TESTING (bench overrides GATE_CYCLES=2000 -> 100 us gate, FREQ_MULT=10000, SETTLE_CYCLES=4)
//  1 rst held 10 cycles, ch_en=4'hF, inputs toggling -> all outputs 0, busy=0 until release.
//  2 ch_en=4'b0001, ch0 = 100 kHz -> freq_out_0 = 100000, upd_stb each 2006 cycles, upd_ch=0.
//  3 ch_en=4'hF, ch0..3 = 200k/100k/50k/0 Hz -> 200000/100000/50000/0, strobes in order 0,1,2,3,0.
//  4 ch_en=4'b1010 -> only ch1,ch3 alternate; freq_valid[0],[2] stay 0.
//  5 clear ch_en[2] mid-GATE on ch2 -> freq_valid[2] drops next cycle, no strobe, freq_out_2 unchanged.
//  6 rst pulsed mid-GATE -> all outputs back to 0, sweep restarts at ch0 after release.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared constants, FSM state type and round-robin helper for the frequency scheduler
package freq_meas_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, GATE, STORE} state_t;
  // first enabled channel strictly after last (wrapping); last itself only if it is the sole one
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] last, input logic [NUM_CH-1:0] en);
    logic [CH_W-1:0] c;
    next_ch = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = last + CH_W'(k);
      if (en[c]) next_ch = c;
    end
  endfunction
endpackage

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: two-flop synchroniser bringing one asynchronous pulse pin into the clk domain
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output logic o_level
);
  logic [1:0] r_sync;
  // shift the raw pin through two flops to resolve metastability
  always_ff @(posedge clk)
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[0], i_pulse};
  assign o_level = r_sync[1];
endmodule

// File: rtl/freq_meas_scheduler.sv
// freq_meas_scheduler: round-robin gated edge counter shared across four pulse channels
module freq_meas_scheduler
  import freq_meas_pkg::*;
#(
  parameter int CLK_HZ        = 20_000_000,
  parameter int GATE_CYCLES   = 20_000_000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in_0,
  input  logic              pulse_in_1,
  input  logic              pulse_in_2,
  input  logic              pulse_in_3,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [31:0]       freq_out_0,
  output logic [31:0]       freq_out_1,
  output logic [31:0]       freq_out_2,
  output logic [31:0]       freq_out_3,
  output logic [NUM_CH-1:0] freq_valid,
  output logic              upd_stb,
  output logic [CH_W-1:0]   upd_ch,
  output logic              busy
);
  localparam logic [31:0] FREQ_MULT = 32'(CLK_HZ / GATE_CYCLES);
  logic [NUM_CH-1:0] w_pin, w_sync, r_valid;
  state_t            r_state, w_next;
  logic [CH_W-1:0]   r_cur, r_last, r_upd_ch, w_sel;
  logic [31:0]       r_tmr;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_freq [NUM_CH];
  logic [63:0]       w_prod;
  logic [31:0]       w_scaled;
  logic              r_prev, r_stb, w_lvl, w_edge, w_tmr_done;
  assign w_pin = {pulse_in_3, pulse_in_2, pulse_in_1, pulse_in_0};
  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    pulse_sync_edge u_sync (.clk(clk), .rst(rst), .i_pulse(w_pin[g]), .o_level(w_sync[g]));
  end
  assign w_sel      = next_ch(r_last, ch_en);
  assign w_lvl      = w_sync[r_cur];
  assign w_edge     = w_lvl & ~r_prev;
  assign w_tmr_done = (r_state == SETTLE) ? r_tmr == 32'(SETTLE_CYCLES - 1) : r_tmr == 32'(GATE_CYCLES - 1);
  assign w_prod     = 64'(r_cnt) * 64'(FREQ_MULT);
  assign w_scaled   = |w_prod[63:32] ? '1 : w_prod[31:0];
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next-state: select, settle, gate, store, then loop back to select
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |ch_en ? SELECT : IDLE;
      SELECT:  w_next = |ch_en ? SETTLE : IDLE;
      SETTLE:  w_next = w_tmr_done ? GATE : SETTLE;
      GATE:    w_next = w_tmr_done ? STORE : GATE;
      STORE:   w_next = SELECT;
      default: w_next = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb
    busy = r_state != IDLE;
  // datapath: channel pointer, timer, shared edge counter, scaled result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur    <= '0;
      r_last   <= '1;
      r_tmr    <= '0;
      r_cnt    <= '0;
      r_prev   <= 1'b0;
      r_valid  <= '0;
      r_stb    <= 1'b0;
      r_upd_ch <= '0;
      for (int n = 0; n < NUM_CH; n++) r_freq[n] <= '0;
    end else begin
      r_stb   <= 1'b0;
      r_valid <= r_valid & ch_en;
      r_tmr   <= ((r_state == SETTLE || r_state == GATE) && !w_tmr_done) ? r_tmr + 32'd1 : '0;
      r_prev  <= (r_state == SELECT) ? w_sync[w_sel] : w_lvl;
      if (r_state == SELECT) r_cur <= w_sel;
      if (r_state == SETTLE) r_cnt <= '0;
      if (r_state == GATE && w_edge && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      if (r_state == STORE) begin
        r_last <= r_cur;
        if (ch_en[r_cur]) begin
          r_freq[r_cur]  <= w_scaled;
          r_valid[r_cur] <= 1'b1;
          r_stb          <= 1'b1;
          r_upd_ch       <= r_cur;
        end
      end
    end
  end
  assign freq_out_0 = r_freq[0];
  assign freq_out_1 = r_freq[1];
  assign freq_out_2 = r_freq[2];
  assign freq_out_3 = r_freq[3];
  assign freq_valid = r_valid;
  assign upd_stb    = r_stb;
  assign upd_ch     = r_upd_ch;
endmodule
